// File: rtl/fifo_flags_pkg.sv
// fifo_flags_pkg: derived sizes and parameter legality checks for fifo_flags
package fifo_flags_pkg;
  localparam int DEPTH_LOG2_DEF = 5;
  function automatic int depth_of(int depth_log2);
    return 1 << depth_log2;
  endfunction
  localparam int DEPTH = depth_of(DEPTH_LOG2_DEF);
  function automatic int cnt_w(int depth_log2);
    return depth_log2 + 1;
  endfunction
  function automatic bit levels_ok(int depth_log2, int af_level, int ae_level);
    return af_level >= 1 && af_level <= depth_of(depth_log2) && ae_level >= 0 && ae_level < af_level;
  endfunction
endpackage

// File: rtl/fifo_flags_ram.sv
// fifo_flags_ram: dual-port storage, synchronous write, asynchronous read, no reset
module fifo_flags_ram #(
  parameter int WIDTH = 9,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_flags.sv
// fifo_flags: parametrised FIFO with FWFT/registered read, level flags, count and sticky errors
module fifo_flags
  import fifo_flags_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH_LOG2 = 5,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 1
) (
  input  logic                  clk,
  input  logic                  rstp,
  input  logic                  flushp,
  input  logic                  clr_err,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  writep,
  input  logic                  readp,
  output logic [WIDTH-1:0]      data_out,
  output logic                  rd_valid,
  output logic                  emptyp,
  output logic                  fullp,
  output logic                  almost_emptyp,
  output logic                  almost_fullp,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int CW = cnt_w(DEPTH_LOG2);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(depth_of(DEPTH_LOG2));
  localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
  localparam logic [DEPTH_LOG2-1:0] P1 = DEPTH_LOG2'(1);
  if (!levels_ok(DEPTH_LOG2, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("fifo_flags: AF_LEVEL must be 1..DEPTH and AE_LEVEL < AF_LEVEL");
  end
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_nxt;
  logic wr_acc, rd_acc, wr_en, rd_en;
  logic [WIDTH-1:0] rdata;
  // a write into a full FIFO is only legal when a read frees the slot in the same cycle
  assign wr_acc = writep & (!fullp | readp);
  assign rd_acc = readp & !emptyp;
  assign wr_en = wr_acc & !flushp;
  assign rd_en = rd_acc & !flushp;
  always_comb
    cnt_nxt = flushp ? '0 : (wr_en & !rd_en) ? count + C1 : (rd_en & !wr_en) ? count - C1 : count;
  fifo_flags_ram #(.WIDTH(WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk(clk), .we(wr_en), .waddr(wr_ptr), .wdata(data_in), .raddr(rd_ptr), .rdata(rdata)
  );
  // flags come from the next count so they never lag count
  always_ff @(posedge clk or posedge rstp)
    if (rstp) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      emptyp <= 1'b1;
      fullp <= 1'b0;
      almost_emptyp <= 1'b1;
      almost_fullp <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= flushp ? '0 : wr_en ? wr_ptr + P1 : wr_ptr;
      rd_ptr <= flushp ? '0 : rd_en ? rd_ptr + P1 : rd_ptr;
      count <= cnt_nxt;
      emptyp <= cnt_nxt == '0;
      fullp <= cnt_nxt == FULL_C;
      almost_emptyp <= cnt_nxt <= AE_C;
      almost_fullp <= cnt_nxt >= AF_C;
      overflow <= (writep & !wr_acc & !flushp) | (overflow & !clr_err);
      underflow <= (readp & !rd_acc & !flushp) | (underflow & !clr_err);
    end
  if (FWFT != 0) begin : g_fwft
    assign data_out = rdata;
    assign rd_valid = !emptyp;
  end else begin : g_reg
    logic [WIDTH-1:0] data_q;
    logic vld_q;
    always_ff @(posedge clk or posedge rstp)
      if (rstp) begin
        data_q <= '0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= rd_en;
        if (rd_en) data_q <= rdata;
      end
    assign data_out = data_q;
    assign rd_valid = vld_q;
  end
endmodule

// File: tb/tb_fifo_flags.sv
// tb_fifo_flags: queue-model check of fifo_flags in FWFT and registered-read modes
module tb_fifo_flags;
  logic clk = 0, rstp = 1, flushp = 0, clr_err = 0, writep = 0, readp = 0;
  logic [8:0] data_in = 0;
  logic [8:0] d1, d0;
  logic v1, v0, e1, e0, f1, f0, ae1, ae0, af1, af0, o1, o0, u1, u0;
  logic [5:0] c1, c0;
  int errs = 0, checks = 0;
  bit started = 0;
  logic [8:0] q[$];
  bit m_ovf = 0, m_udf = 0, m_vld0 = 0;
  logic [8:0] m_dout0 = 0;

  always #5 clk = ~clk;

  fifo_flags #(.FWFT(1)) dut1 (
    .clk(clk), .rstp(rstp), .flushp(flushp), .clr_err(clr_err), .data_in(data_in),
    .writep(writep), .readp(readp), .data_out(d1), .rd_valid(v1), .emptyp(e1),
    .fullp(f1), .almost_emptyp(ae1), .almost_fullp(af1), .count(c1),
    .overflow(o1), .underflow(u1)
  );
  fifo_flags #(.FWFT(0)) dut0 (
    .clk(clk), .rstp(rstp), .flushp(flushp), .clr_err(clr_err), .data_in(data_in),
    .writep(writep), .readp(readp), .data_out(d0), .rd_valid(v0), .emptyp(e0),
    .fullp(f0), .almost_emptyp(ae0), .almost_fullp(af0), .count(c0),
    .overflow(o0), .underflow(u0)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    m_vld0 = 0;
    m_dout0 = 0;
  endtask

  // applies the inputs present at the edge just taken
  task automatic model_update();
    bit wa, ra;
    if (flushp) begin
      q.delete();
      m_vld0 = 0;
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
    end else begin
      wa = writep && (q.size() < 32 || readp);
      ra = readp && q.size() > 0;
      m_ovf = (writep && !wa) || (m_ovf && !clr_err);
      m_udf = (readp && !ra) || (m_udf && !clr_err);
      m_vld0 = ra;
      if (ra) m_dout0 = q.pop_front();
      if (wa) q.push_back(data_in);
    end
  endtask

  task automatic step(bit w, bit r, bit f, bit c, logic [8:0] d);
    writep = w; readp = r; flushp = f; clr_err = c; data_in = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    writep = 0; readp = 0; flushp = 0; clr_err = 0;
  endtask

  always @(negedge clk)
    if (started && !rstp) begin
      chk("count1", c1, q.size());
      chk("count0", c0, q.size());
      chk("empty1", e1, q.size() == 0);
      chk("empty0", e0, q.size() == 0);
      chk("full1", f1, q.size() == 32);
      chk("full0", f0, q.size() == 32);
      chk("aempty1", ae1, q.size() <= 2);
      chk("aempty0", ae0, q.size() <= 2);
      chk("afull1", af1, q.size() >= 28);
      chk("afull0", af0, q.size() >= 28);
      chk("ovf1", o1, m_ovf);
      chk("ovf0", o0, m_ovf);
      chk("udf1", u1, m_udf);
      chk("udf0", u0, m_udf);
      chk("valid1", v1, q.size() != 0);
      if (q.size() != 0) chk("dout1", d1, q[0]);
      chk("valid0", v0, m_vld0);
      chk("dout0", d0, m_dout0);
    end

  initial begin
    #12 rstp = 0;
    @(negedge clk);
    chk("rst_count", c1, 0);
    chk("rst_empty", e1, 1);
    chk("rst_aempty", ae1, 1);
    chk("rst_afull", af1, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_valid0", v0, 0);
    chk("rst_dout0", d0, 0);
    started = 1;
    step(0, 1, 0, 0, 0);
    chk("udf_empty", u1, 1);
    chk("udf_count", c1, 0);
    step(0, 0, 0, 1, 0);
    chk("clr_udf", u1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    chk("clr_vs_set", u1, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 1; i <= 32; i++) begin
      step(1, 0, 0, 0, 9'(i));
      if (i == 27) chk("afull_27", af1, 0);
      if (i == 28) chk("afull_28", af1, 1);
    end
    chk("full_32", f1, 1);
    chk("count_32", c1, 32);
    step(1, 0, 0, 0, 9'h021);
    chk("ovf_33", o1, 1);
    chk("count_hold", c1, 32);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 9'(9'h021 + i));
    chk("wrap_count", c1, 32);
    chk("wrap_head", d1, 9'h00B);
    chk("wrap_dout0", d0, 9'h00A);
    chk("wrap_noovf", o1, 0);
    for (int i = 0; i < 32; i++) step(0, 1, 0, 0, 0);
    chk("drained", c1, 0);
    step(1, 1, 0, 0, 9'h1EE);
    chk("wr_rd_empty_cnt", c1, 1);
    chk("wr_rd_empty_udf", u1, 1);
    chk("wr_rd_empty_dout", d1, 9'h1EE);
    step(0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 9'h0AA);
    step(1, 0, 0, 0, 9'h055);
    step(0, 1, 0, 0, 0);
    chk("reg_d1", d0, 9'h0AA);
    chk("reg_v1", v0, 1);
    step(0, 1, 0, 0, 0);
    chk("reg_d2", d0, 9'h055);
    step(0, 0, 0, 0, 0);
    chk("reg_v_off", v0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 9'(9'h100 + i));
    step(1, 0, 1, 0, 9'h111);
    chk("flush_count", c1, 0);
    chk("flush_empty", e1, 1);
    chk("flush_err_kept", u1, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = (i / 300) % 3 == 0 ? 70 : (i / 300) % 3 == 1 ? 30 : 50;
      step($urandom_range(99) < wp, $urandom_range(99) < 100 - wp + 10,
           $urandom_range(63) == 0, $urandom_range(15) == 0, 9'($urandom_range(511)));
    end
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 9'(9'h080 + i));
    writep = 1; readp = 1; data_in = 9'h0F0;
    @(posedge clk);
    model_update();
    #2 rstp = 1;
    #1;
    chk("arst_count", c1, 0);
    chk("arst_empty", e1, 1);
    chk("arst_full", f1, 0);
    chk("arst_aempty", ae0, 1);
    chk("arst_afull", af0, 0);
    chk("arst_valid1", v1, 0);
    chk("arst_valid0", v0, 0);
    chk("arst_dout0", d0, 0);
    chk("arst_ovf", o0, 0);
    chk("arst_udf", u0, 0);
    model_reset();
    writep = 0; readp = 0;
    @(negedge clk);
    rstp = 0;
    step(1, 0, 0, 0, 9'h033);
    chk("post_rst_dout", d1, 9'h033);
    step(0, 1, 0, 0, 0);
    chk("post_rst_rd", d0, 9'h033);
    step(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO, successor to the team's fixed 9-bit/32-entry buffer. Generic in data width and depth. Adds:
- Selectable first-word-fall-through (FWFT) or registered-read output mode.
- Programmable almost-full/almost-empty thresholds.
- An occupancy count output.
- Sticky overflow/underflow error flags.
- A synchronous flush.

It sits between packet producers and consumers in the datapath wherever rate decoupling plus early back-pressure is needed.

## Interface
- WIDTH, 9, data word width in bits
- DEPTH_LOG2, 5, log2 of entry count; DEPTH = 2**DEPTH_LOG2 (32)
- AF_LEVEL, 28, almost_fullp asserted when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_emptyp asserted when count <= AE_LEVEL (0..DEPTH-1)
- FWFT, 1, 1 = show-ahead output, 0 = registered read data one cycle after readp
- clk  in  1  clock, all state on rising edge
- rstp  in  1  reset, asynchronous, active-high
- flushp  in  1  synchronous flush, empties FIFO
- clr_err  in  1  synchronous clear of overflow/underflow
- data_in  in  WIDTH  write data
- writep  in  1  write request
- readp  in  1  read request
- data_out  out  WIDTH  read data
- rd_valid  out  1  data_out valid qualifier
- emptyp  out  1  count == 0
- fullp  out  1  count == DEPTH
- almost_emptyp  out  1  count <= AE_LEVEL
- almost_fullp  out  1  count >= AF_LEVEL
- count  out  DEPTH_LOG2+1  current occupancy 0..DEPTH
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation
- Storage is DEPTH x WIDTH. The write pointer wr_ptr and read pointer rd_ptr are each DEPTH_LOG2 bits and wrap naturally modulo DEPTH.
- The memory array is not reset.
- Accepted write: wr_acc = writep & (!fullp | readp). When full, a write is accepted only together with a simultaneous read.
- Accepted read: rd_acc = readp & !emptyp. When empty, a read is never accepted, even if a write occurs in the same cycle.
- Count update:
  - wr_acc only: count + 1.
  - rd_acc only: count - 1.
  - Both: unchanged, and both pointers advance.
- All flags are registered. They are computed from the next-state count, so flags and count always agree in the same cycle.
- overflow is set when writep & !wr_acc.
- underflow is set when readp & !rd_acc.
- The error flags hold until clr_err. If clr_err and a new error occur in the same cycle, the set wins.
- flushp has priority over readp/writep. On flush:
  - Pointers and count go to 0, and the flags return to their reset values.
  - rd_valid goes to 0.
  - Error flags are unaffected.
- FWFT=1:
  - data_out = mem[rd_ptr] at all times.
  - rd_valid = !emptyp.
  - readp acknowledges the word currently shown.
- FWFT=0:
  - On rd_acc, data_out is loaded with mem[rd_ptr].
  - rd_valid is pulsed high for the following cycle only.
  - data_out holds its value otherwise.
- Reset values: count 0, emptyp 1, fullp 0, almost_emptyp 1, almost_fullp 0, overflow 0, underflow 0, rd_valid 0, data_out 0 in FWFT=0 mode. In FWFT=1 mode data_out is don't-care while emptyp is high.

## Timing
- An accepted write at edge N is visible on count/flags after edge N.
  - FWFT=1: a write into an empty FIFO appears on data_out with rd_valid=1 in the cycle after edge N.
  - Write-to-read latency is 1 cycle.
- FWFT=0 read: readp sampled at edge N gives data_out/rd_valid valid after edge N, deasserting after edge N+1 unless another read is accepted.
- Full/empty boundaries:
  - Write while full without readp: rejected, overflow set after the edge, count stays DEPTH.
  - Read while empty: rejected, underflow set after the edge.
- Wrap-around: after DEPTH+k writes and DEPTH+k reads, ordering is preserved across the pointer wrap.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- The first edge after rstp deasserts behaves as normal operation.

## Structure
- Package fifo_flags_pkg holds:
  - The derived constant DEPTH.
  - A count width function (DEPTH_LOG2+1).
  - The parameter legality checks: AF_LEVEL in 1..DEPTH, AE_LEVEL < AF_LEVEL.
- Sub-module fifo_flags_ram: simple dual-port array with a synchronous write port and an asynchronous read port. FWFT=0 adds the output register in the top level.
- The top level holds the pointers, count, flag registers, error logic and flush.

## Test plan
- Defaults, FWFT=1: write 0x001..0x020 (32 words), then 1 more.
  - fullp=1 after the 32nd write.
  - almost_fullp=1 from count 28.
  - The 33rd write sets overflow and count stays 32.
  - Reads return 0x001..0x020 in order.
- Read on empty after reset: underflow=1, count=0.
  - clr_err with no new error clears it next cycle.
  - clr_err coinciding with another empty read keeps underflow=1.
- Full FIFO, writep=readp=1 for 10 cycles: count stays 32, all 10 writes accepted, and the data order continues correctly across the wrap.
- Empty FIFO, writep=readp=1 in one cycle: write accepted, read rejected, underflow set, count=1.
- FWFT=0: write 0x0AA, 0x055, then readp for 2 cycles.
  - data_out=0x0AA with rd_valid after the first edge.
  - data_out=0x055 after the second edge.
  - rd_valid=0 in the cycle after that.
- Write 5 words, assert flushp with writep in the same cycle: count=0, emptyp=1, the write is ignored, and the error flags are unchanged.
- Separately, assert rstp asynchronously mid-burst: all outputs return to reset values before the next clk edge.
